// File: rtl/game_sequencer.sv
// Game flow controller: frame ticks -> env_step pulses, score/level tracking, IDLE/PLAY/PAUSED/LEVEL_UP/GAME_OVER FSM.
// Latency: every output is registered, so it reflects inputs sampled on the previous clk edge.
// Backpressure: none; pulse inputs are consumed on the cycle they are seen or dropped by state.
module game_sequencer #(
    parameter int STEP_DIV       = 4,
    parameter int BARS_PER_LEVEL = 8,
    parameter int MAX_LEVEL      = 9,
    parameter int LEVEL_HOLD     = 60,
    parameter int OVER_HOLD      = 120
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame_tick,
    input  logic       i_start_btn,
    input  logic       i_pause_btn,
    input  logic       i_collision,
    input  logic       i_bar_passed,
    output logic [2:0] o_state,
    output logic [9:0] o_level,
    output logic       o_pause,
    output logic       o_env_step,
    output logic [9:0] o_score,
    output logic [3:0] o_bars_cleared,
    output logic       o_game_over
);

    localparam int SW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HMAX = (LEVEL_HOLD > OVER_HOLD) ? LEVEL_HOLD : OVER_HOLD;
    localparam int HW   = $clog2(HMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLAY      = 3'd1,
        S_PAUSED    = 3'd2,
        S_LEVEL_UP  = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    state_t        r_state,    w_state;
    logic [9:0]    r_level,    w_level;
    logic [9:0]    r_score,    w_score;
    logic [3:0]    r_bars,     w_bars;
    logic [SW-1:0] r_step_cnt, w_step_cnt;
    logic [HW-1:0] r_hold_cnt, w_hold_cnt;
    logic          r_pause,    w_pause;
    logic          r_env_step, w_env_step;
    logic          r_game_over, w_game_over;
    logic          w_step_wrap;

    logic [9:0]    w_score_inc;
    logic [3:0]    w_bars_inc;
    logic [9:0]    w_level_inc;

    assign w_score_inc = (r_score == 10'd1023) ? r_score : r_score + 10'd1;
    assign w_bars_inc  = r_bars + 4'd1;
    assign w_level_inc = (r_level >= 10'(MAX_LEVEL)) ? 10'(MAX_LEVEL) : r_level + 10'd1;

    always_comb begin
        w_state     = r_state;
        w_level     = r_level;
        w_score     = r_score;
        w_bars      = r_bars;
        w_step_cnt  = r_step_cnt;
        w_hold_cnt  = r_hold_cnt;
        w_step_wrap = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start_btn) begin
                    w_state    = S_PLAY;
                    w_score    = '0;
                    w_bars     = '0;
                    w_step_cnt = '0;
                    w_level    = 10'd1;
                end
            end
            S_PLAY: begin
                // The step counter consumes this tick even if the state changes now.
                if (i_frame_tick) begin
                    if (r_step_cnt == SW'(STEP_DIV - 1)) begin
                        w_step_cnt  = '0;
                        w_step_wrap = 1'b1;
                    end else begin
                        w_step_cnt = r_step_cnt + 1'b1;
                    end
                end
                if (i_collision) begin
                    w_state    = S_GAME_OVER;
                    w_hold_cnt = '0;
                end else if (i_bar_passed) begin
                    w_score = w_score_inc;
                    if (w_bars_inc == 4'(BARS_PER_LEVEL)) begin
                        w_state    = S_LEVEL_UP;
                        w_bars     = '0;
                        w_level    = w_level_inc;
                        w_hold_cnt = '0;
                    end else begin
                        w_bars = w_bars_inc;
                        if (i_pause_btn) begin
                            w_state = S_PAUSED;
                        end
                    end
                end else if (i_pause_btn) begin
                    w_state = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (i_pause_btn) begin
                    w_state = S_PLAY;
                end
            end
            S_LEVEL_UP: begin
                if (i_frame_tick) begin
                    if (r_hold_cnt == HW'(LEVEL_HOLD - 1)) begin
                        w_state    = S_PLAY;
                        w_step_cnt = '0;
                    end else begin
                        w_hold_cnt = r_hold_cnt + 1'b1;
                    end
                end
            end
            S_GAME_OVER: begin
                if (i_frame_tick && (r_hold_cnt < HW'(OVER_HOLD))) begin
                    w_hold_cnt = r_hold_cnt + 1'b1;
                end
                if (i_start_btn && (r_hold_cnt == HW'(OVER_HOLD))) begin
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // A wrap on the cycle PLAY is left must not leak a step into a frozen state.
        w_env_step  = w_step_wrap && (w_state == S_PLAY);
        w_pause     = (w_state != S_PLAY);
        w_game_over = (w_state == S_GAME_OVER);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_level     <= 10'd1;
            r_score     <= '0;
            r_bars      <= '0;
            r_step_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_pause     <= 1'b1;
            r_env_step  <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_level     <= w_level;
            r_score     <= w_score;
            r_bars      <= w_bars;
            r_step_cnt  <= w_step_cnt;
            r_hold_cnt  <= w_hold_cnt;
            r_pause     <= w_pause;
            r_env_step  <= w_env_step;
            r_game_over <= w_game_over;
        end
    end

    assign o_state        = r_state;
    assign o_level        = r_level;
    assign o_pause        = r_pause;
    assign o_env_step     = r_env_step;
    assign o_score        = r_score;
    assign o_bars_cleared = r_bars;
    assign o_game_over    = r_game_over;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with default parameters (STEP_DIV=4, BARS=8, MAX=9, holds 60/120).
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       start_btn;
    logic       pause_btn;
    logic       collision;
    logic       bar_passed;
    logic [2:0] o_state;
    logic [9:0] o_level;
    logic       o_pause;
    logic       o_env_step;
    logic [9:0] o_score;
    logic [3:0] o_bars_cleared;
    logic       o_game_over;

    int checks = 0;
    int errors = 0;
    int n_steps = 0;
    int run_hi = 0;
    int max_run = 0;

    logic [29:0] rst_vec;
    logic [29:0] rst_exp;

    always #5 clk = ~clk;

    game_sequencer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_frame_tick  (frame_tick),
        .i_start_btn   (start_btn),
        .i_pause_btn   (pause_btn),
        .i_collision   (collision),
        .i_bar_passed  (bar_passed),
        .o_state       (o_state),
        .o_level       (o_level),
        .o_pause       (o_pause),
        .o_env_step    (o_env_step),
        .o_score       (o_score),
        .o_bars_cleared(o_bars_cleared),
        .o_game_over   (o_game_over)
    );

    assign rst_vec = {o_state, o_level, o_pause, o_env_step, o_score, o_bars_cleared, o_game_over};

    // One clock, outputs observed 1 time unit after the edge; tracks env_step pulse count/width.
    task automatic clk1();
        @(posedge clk);
        #1;
        if (o_env_step === 1'b1) begin
            n_steps++;
            run_hi++;
            if (run_hi > max_run) max_run = run_hi;
        end else begin
            run_hi = 0;
        end
    endtask

    task automatic clear_steps();
        n_steps = 0;
        run_hi  = 0;
        max_run = 0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        clk1();
        frame_tick = 1'b0;
        clk1();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        clk1();
        start_btn = 1'b0;
    endtask

    task automatic press_pause();
        pause_btn = 1'b1;
        clk1();
        pause_btn = 1'b0;
    endtask

    task automatic pass_bar();
        bar_passed = 1'b1;
        clk1();
        bar_passed = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clk1();
        clk1();
        rst = 1'b0;
        checks++;
        if (rst_vec !== rst_exp) begin
            errors++;
            $display("FAIL reset_vals got %h want %h", rst_vec, rst_exp);
        end
        clk1();
        checks++;
        if (o_state !== 3'd0) begin
            errors++;
            $display("FAIL idle_hold state got %0d want 0", o_state);
        end
    endtask

    task automatic test_play_steps();
        press_start();
        checks++;
        if (o_state !== 3'd1 || o_pause !== 1'b0 || o_level !== 10'd1 || o_score !== 10'd0) begin
            errors++;
            $display("FAIL start_play state=%0d pause=%0d level=%0d score=%0d want 1/0/1/0",
                     o_state, o_pause, o_level, o_score);
        end
        clear_steps();
        for (int i = 1; i <= 8; i++) begin
            frame_tick = 1'b1;
            clk1();
            frame_tick = 1'b0;
            checks++;
            if (o_env_step !== ((i % 4) == 0)) begin
                errors++;
                $display("FAIL step_after_tick%0d got %0d want %0d", i, o_env_step, (i % 4) == 0);
            end
            clk1();
            checks++;
            if (o_env_step !== 1'b0 || o_pause !== 1'b0) begin
                errors++;
                $display("FAIL step_gap%0d env_step=%0d pause=%0d want 0/0", i, o_env_step, o_pause);
            end
        end
        checks++;
        if (n_steps != 2 || max_run != 1) begin
            errors++;
            $display("FAIL step_count pulses=%0d width=%0d want 2/1", n_steps, max_run);
        end
    endtask

    task automatic test_level_up();
        for (int i = 0; i < 7; i++) pass_bar();
        checks++;
        if (o_score !== 10'd7 || o_bars_cleared !== 4'd7 || o_state !== 3'd1) begin
            errors++;
            $display("FAIL seven_bars score=%0d bars=%0d state=%0d want 7/7/1",
                     o_score, o_bars_cleared, o_state);
        end
        pass_bar();
        checks++;
        if (o_score !== 10'd8 || o_bars_cleared !== 4'd0 || o_state !== 3'd3 ||
            o_level !== 10'd2 || o_pause !== 1'b1) begin
            errors++;
            $display("FAIL level_up score=%0d bars=%0d state=%0d level=%0d pause=%0d want 8/0/3/2/1",
                     o_score, o_bars_cleared, o_state, o_level, o_pause);
        end
        clear_steps();
        ticks(59);
        checks++;
        if (o_state !== 3'd3) begin
            errors++;
            $display("FAIL hold_59 state got %0d want 3", o_state);
        end
        tick();
        checks++;
        if (o_state !== 3'd1 || o_pause !== 1'b0 || n_steps != 0) begin
            errors++;
            $display("FAIL hold_done state=%0d pause=%0d steps=%0d want 1/0/0", o_state, o_pause, n_steps);
        end
    endtask

    task automatic test_collision();
        collision  = 1'b1;
        bar_passed = 1'b1;
        clk1();
        collision  = 1'b0;
        bar_passed = 1'b0;
        checks++;
        if (o_state !== 3'd4 || o_game_over !== 1'b1 || o_score !== 10'd8 ||
            o_pause !== 1'b1 || o_level !== 10'd2) begin
            errors++;
            $display("FAIL collide state=%0d go=%0d score=%0d pause=%0d level=%0d want 4/1/8/1/2",
                     o_state, o_game_over, o_score, o_pause, o_level);
        end
        ticks(10);
        press_start();
        checks++;
        if (o_state !== 3'd4) begin
            errors++;
            $display("FAIL over_early_start state got %0d want 4", o_state);
        end
        ticks(109);
        press_start();
        checks++;
        if (o_state !== 3'd4) begin
            errors++;
            $display("FAIL over_119_start state got %0d want 4", o_state);
        end
        tick();
        press_start();
        checks++;
        if (o_state !== 3'd0 || o_game_over !== 1'b0 || o_pause !== 1'b1 || o_score !== 10'd8) begin
            errors++;
            $display("FAIL over_to_idle state=%0d go=%0d pause=%0d score=%0d want 0/0/1/8",
                     o_state, o_game_over, o_pause, o_score);
        end
    endtask

    task automatic test_pause();
        press_start();
        clear_steps();
        ticks(2);
        press_pause();
        checks++;
        if (o_state !== 3'd2 || o_pause !== 1'b1) begin
            errors++;
            $display("FAIL paused state=%0d pause=%0d want 2/1", o_state, o_pause);
        end
        ticks(5);
        collision  = 1'b1;
        bar_passed = 1'b1;
        start_btn  = 1'b1;
        clk1();
        collision  = 1'b0;
        bar_passed = 1'b0;
        start_btn  = 1'b0;
        checks++;
        if (o_state !== 3'd2 || o_score !== 10'd0 || n_steps != 0) begin
            errors++;
            $display("FAIL paused_ignore state=%0d score=%0d steps=%0d want 2/0/0", o_state, o_score, n_steps);
        end
        press_pause();
        checks++;
        if (o_state !== 3'd1 || o_pause !== 1'b0) begin
            errors++;
            $display("FAIL resume state=%0d pause=%0d want 1/0", o_state, o_pause);
        end
        tick();
        checks++;
        if (n_steps != 0) begin
            errors++;
            $display("FAIL resume_tick1 steps got %0d want 0", n_steps);
        end
        tick();
        checks++;
        if (n_steps != 1) begin
            errors++;
            $display("FAIL resume_tick2 steps got %0d want 1", n_steps);
        end
        bar_passed = 1'b1;
        pause_btn  = 1'b1;
        clk1();
        bar_passed = 1'b0;
        pause_btn  = 1'b0;
        checks++;
        if (o_state !== 3'd2 || o_score !== 10'd1 || o_bars_cleared !== 4'd1) begin
            errors++;
            $display("FAIL bar_and_pause state=%0d score=%0d bars=%0d want 2/1/1",
                     o_state, o_score, o_bars_cleared);
        end
    endtask

    task automatic test_max_level();
        rst = 1'b1;
        clk1();
        rst = 1'b0;
        press_start();
        for (int lv = 1; lv <= 9; lv++) begin
            for (int b = 0; b < 8; b++) pass_bar();
            checks++;
            if (o_state !== 3'd3 || o_level !== 10'((lv < 9) ? lv + 1 : 9)) begin
                errors++;
                $display("FAIL lvl_step%0d state=%0d level=%0d want 3/%0d",
                         lv, o_state, o_level, (lv < 9) ? lv + 1 : 9);
            end
            if (lv < 9) ticks(60);
        end
        checks++;
        if (o_level !== 10'd9 || o_score !== 10'd72 || o_bars_cleared !== 4'd0) begin
            errors++;
            $display("FAIL max_level level=%0d score=%0d bars=%0d want 9/72/0",
                     o_level, o_score, o_bars_cleared);
        end
    endtask

    task automatic test_reset_mid();
        ticks(5);
        checks++;
        if (o_state !== 3'd3) begin
            errors++;
            $display("FAIL pre_rst_lvlup state got %0d want 3", o_state);
        end
        rst = 1'b1;
        clk1();
        rst = 1'b0;
        checks++;
        if (rst_vec !== rst_exp) begin
            errors++;
            $display("FAIL rst_in_levelup got %h want %h", rst_vec, rst_exp);
        end
        press_start();
        tick();
        press_pause();
        ticks(3);
        checks++;
        if (o_state !== 3'd2) begin
            errors++;
            $display("FAIL pre_rst_paused state got %0d want 2", o_state);
        end
        rst = 1'b1;
        clk1();
        rst = 1'b0;
        checks++;
        if (rst_vec !== rst_exp) begin
            errors++;
            $display("FAIL rst_in_paused got %h want %h", rst_vec, rst_exp);
        end
        press_start();
        clear_steps();
        ticks(8);
        checks++;
        if (n_steps != 2 || max_run != 1 || o_state !== 3'd1) begin
            errors++;
            $display("FAIL post_rst_play steps=%0d width=%0d state=%0d want 2/1/1",
                     n_steps, max_run, o_state);
        end
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        start_btn  = 1'b0;
        pause_btn  = 1'b0;
        collision  = 1'b0;
        bar_passed = 1'b0;
        rst_exp    = {3'd0, 10'd1, 1'b1, 1'b0, 10'd0, 4'd0, 1'b0};
        test_reset();
        test_play_steps();
        test_level_up();
        test_collision();
        test_pause();
        test_max_level();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
